// File: rtl/input_conditioner_pkg.sv
// input_cond_pkg: default parameters, repeat FSM states and counter width helper for input_conditioner
package input_cond_pkg;
  localparam int DEF_NUM_BTN = 5;
  localparam int DEF_NUM_SW = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TICK_DIV = 100000;
  localparam int DEF_DB_TICKS = 5;
  localparam int DEF_REPEAT_DELAY = 500;
  localparam int DEF_REPEAT_RATE = 100;
  typedef enum logic [1:0] {IDLE, DELAY, RATE} rpt_state_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw inputs and conditioned outputs of input_conditioner
interface input_conditioner_if #(
  parameter int NUM_BTN = input_cond_pkg::DEF_NUM_BTN,
  parameter int NUM_SW = input_cond_pkg::DEF_NUM_SW
);
  logic [NUM_BTN-1:0] pbtn_in, pbtn_db, pbtn_press, pbtn_release, pbtn_repeat;
  logic [NUM_SW-1:0] switch_in, swtch_db, swtch_chg;
  modport master (
    output pbtn_in, switch_in,
    input pbtn_db, pbtn_press, pbtn_release, pbtn_repeat, swtch_db, swtch_chg
  );
  modport slave (
    input pbtn_in, switch_in,
    output pbtn_db, pbtn_press, pbtn_release, pbtn_repeat, swtch_db, swtch_chg
  );
endinterface

// File: rtl/input_conditioner_db_channel.sv
// db_channel: synchronizer, tick-based debounce counter and registered rise/fall pulses for one input
module db_channel import input_cond_pkg::*; #(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_TICKS = DEF_DB_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam int CW = cw(DB_TICKS);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s, flip;
  assign s = sync[SYNC_STAGES-1];
  assign flip = s != db && tick && cnt == CW'(DB_TICKS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      db <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= flip && s;
      fall <= flip && !s;
      db <= flip ? s : db;
      cnt <= (s == db || flip) ? '0 : tick ? cnt + CW'(1) : cnt;
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces buttons and switches on a shared tick, with per-button auto-repeat
module input_conditioner import input_cond_pkg::*; #(
  parameter int NUM_BTN = DEF_NUM_BTN,
  parameter int NUM_SW = DEF_NUM_SW,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int DB_TICKS = DEF_DB_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input logic clk,
  input logic rst,
  input_conditioner_if.slave io
);
  localparam int PW = cw(TICK_DIV);
  localparam int RW = cw(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
  logic [1:0] rst_sync;
  logic rst_n, tick;
  logic [PW-1:0] pcnt;
  logic [NUM_BTN-1:0] btn_db, btn_rise, btn_fall, btn_rpt;
  logic [NUM_SW-1:0] sw_rise, sw_fall;
  // reset takes effect at once but is released two clk edges later
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  assign tick = pcnt == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + PW'(1);
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    rpt_state_t st;
    logic [RW-1:0] rc;
    logic rpt;
    db_channel #(.SYNC_STAGES(SYNC_STAGES), .DB_TICKS(DB_TICKS)) u_db (
      .clk(clk), .rst_n(rst_n), .raw(io.pbtn_in[b]), .tick(tick),
      .db(btn_db[b]), .rise(btn_rise[b]), .fall(btn_fall[b])
    );
    // the press edge is always a tick, so the first counted tick is the one after it
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st <= IDLE;
        rc <= '0;
        rpt <= 1'b0;
      end else begin
        rpt <= 1'b0;
        if (st == IDLE) begin
          rc <= '0;
          st <= btn_rise[b] ? DELAY : IDLE;
        end else if (!btn_db[b]) begin
          rc <= '0;
          st <= IDLE;
        end else if (tick) begin
          if (rc == RW'((st == DELAY ? REPEAT_DELAY : REPEAT_RATE) - 1)) begin
            rc <= '0;
            rpt <= 1'b1;
            st <= RATE;
          end else rc <= rc + RW'(1);
        end
      end
    // a repeat landing on the release edge is suppressed
    assign btn_rpt[b] = rpt && !btn_fall[b];
  end
  for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
    db_channel #(.SYNC_STAGES(SYNC_STAGES), .DB_TICKS(DB_TICKS)) u_db (
      .clk(clk), .rst_n(rst_n), .raw(io.switch_in[s]), .tick(tick),
      .db(io.swtch_db[s]), .rise(sw_rise[s]), .fall(sw_fall[s])
    );
  end
  assign io.pbtn_db = btn_db;
  assign io.pbtn_press = btn_rise;
  assign io.pbtn_release = btn_fall;
  assign io.pbtn_repeat = btn_rpt;
  assign io.swtch_chg = sw_rise | sw_fall;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random stimulus checked every cycle against a tick-counting reference model
module tb_input_conditioner;
  localparam int NB = 5, NS = 8, NC = NB + NS;
  localparam int SS = 2, TDIV = 4, DB = 3, RD = 5, RR = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0, n_fail = 0, cyc_n = 0;
  int lat, first, tp;
  logic [NC-1:0] q[$];
  logic [NC-1:0] m_db;
  logic [NB-1:0] e_press, e_rel, e_rpt;
  logic [NS-1:0] e_chg;
  int mis[NC];
  int held[NB];
  int k, rel;
  int obs_press[NB], obs_rel[NB], obs_rpt[NB], obs_chg[NS];

  input_conditioner_if #(.NUM_BTN(NB), .NUM_SW(NS)) io ();
  input_conditioner #(
    .NUM_BTN(NB), .NUM_SW(NS), .SYNC_STAGES(SS), .TICK_DIV(TDIV),
    .DB_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < SS; i++) q.push_back('0);
    m_db = '0;
    e_press = '0;
    e_rel = '0;
    e_rpt = '0;
    e_chg = '0;
    k = 0;
    rel = 0;
    for (int c = 0; c < NC; c++) mis[c] = 0;
    for (int b = 0; b < NB; b++) held[b] = -1;
  endfunction

  // one rising edge: inputs seen SS edges ago are debounced; repeats follow ticks held since press
  function automatic void model_edge();
    logic [NC-1:0] s, fl;
    bit tk;
    e_press = '0;
    e_rel = '0;
    e_rpt = '0;
    e_chg = '0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (rel < 2) begin
      rel++;
      return;
    end
    tk = (k % TDIV) == TDIV - 1;
    k++;
    s = q.pop_front();
    q.push_back({io.switch_in, io.pbtn_in});
    fl = '0;
    for (int c = 0; c < NC; c++) begin
      if (s[c] == m_db[c]) mis[c] = 0;
      else if (tk) begin
        mis[c]++;
        if (mis[c] == DB) begin
          m_db[c] = s[c];
          mis[c] = 0;
          fl[c] = 1'b1;
        end
      end
    end
    e_chg = fl[NC-1:NB];
    for (int b = 0; b < NB; b++) begin
      if (fl[b]) begin
        e_press[b] = m_db[b];
        e_rel[b] = !m_db[b];
        held[b] = m_db[b] ? 0 : -1;
      end else if (m_db[b] && tk && held[b] >= 0) begin
        held[b]++;
        e_rpt[b] = held[b] >= RD && (held[b] - RD) % RR == 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pbtn_db", 32'(io.pbtn_db), 32'(m_db[NB-1:0]));
    chk("pbtn_press", 32'(io.pbtn_press), 32'(e_press));
    chk("pbtn_release", 32'(io.pbtn_release), 32'(e_rel));
    chk("pbtn_repeat", 32'(io.pbtn_repeat), 32'(e_rpt));
    chk("swtch_db", 32'(io.swtch_db), 32'(m_db[NC-1:NB]));
    chk("swtch_chg", 32'(io.swtch_chg), 32'(e_chg));
  endtask

  task automatic clr_obs();
    for (int b = 0; b < NB; b++) begin
      obs_press[b] = 0;
      obs_rel[b] = 0;
      obs_rpt[b] = 0;
    end
    for (int i = 0; i < NS; i++) obs_chg[i] = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    cyc_n++;
    for (int b = 0; b < NB; b++) begin
      obs_press[b] += int'(io.pbtn_press[b]);
      obs_rel[b] += int'(io.pbtn_release[b]);
      obs_rpt[b] += int'(io.pbtn_repeat[b]);
    end
    for (int i = 0; i < NS; i++) obs_chg[i] += int'(io.swtch_chg[i]);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    run(2);
    rst = 1'b1;
  endtask

  initial begin
    io.pbtn_in = '0;
    io.switch_in = 8'h80;
    // switch 7 held high through reset
    do_reset();
    clr_obs();
    run(30);
    chk("sw7_db_after_reset", 32'(io.swtch_db[7]), 1);
    chk("sw7_chg_count", 32'(obs_chg[7]), 1);
    // clean press on button 0
    clr_obs();
    io.pbtn_in[0] = 1'b1;
    tp = cyc_n;
    for (int i = 0; i < 40 && !io.pbtn_db[0]; i++) cyc();
    lat = cyc_n - tp;
    chk("btn0_latency_window", 32'(lat >= 8 && lat <= 16), 1);
    run(10);
    chk("btn0_press_count", 32'(obs_press[0]), 1);
    // two-tick glitch on button 1 is ignored
    clr_obs();
    io.pbtn_in[1] = 1'b1;
    run(8);
    io.pbtn_in[1] = 1'b0;
    run(20);
    chk("btn1_glitch_db", 32'(io.pbtn_db[1]), 0);
    chk("btn1_glitch_pulses", 32'(obs_press[1] + obs_rel[1] + obs_rpt[1]), 0);
    // a one-cycle return to the settled level restarts the count from zero
    io.pbtn_in[1] = 1'b1;
    run(8);
    io.pbtn_in[1] = 1'b0;
    cyc();
    io.pbtn_in[1] = 1'b1;
    tp = cyc_n;
    for (int i = 0; i < 40 && !io.pbtn_db[1]; i++) cyc();
    lat = cyc_n - tp;
    chk("btn1_full_redebounce", 32'(lat >= 11 && lat <= 14), 1);
    io.pbtn_in[1] = 1'b0;
    run(20);
    // all switch flips land in the same cycle
    io.switch_in = 8'h00;
    run(30);
    clr_obs();
    io.switch_in = 8'hA5;
    for (int i = 0; i < 40 && io.swtch_chg == '0; i++) cyc();
    chk("sw_chg_vector", 32'(io.swtch_chg), 32'hA5);
    chk("sw_db_vector", 32'(io.swtch_db), 32'hA5);
    cyc();
    chk("sw_chg_one_cycle", 32'(io.swtch_chg), 0);
    // button 2 auto-repeat
    io.pbtn_in[2] = 1'b1;
    for (int i = 0; i < 40 && !io.pbtn_press[2]; i++) cyc();
    chk("btn2_press_seen", 32'(io.pbtn_press[2]), 1);
    clr_obs();
    first = -1;
    for (int i = 1; i <= 80; i++) begin
      cyc();
      if (io.pbtn_repeat[2] && first < 0) first = i;
    end
    chk("btn2_first_repeat", 32'(first), 20);
    chk("btn2_repeat_count", 32'(obs_rpt[2]), 8);
    io.pbtn_in[2] = 1'b0;
    for (int i = 0; i < 40 && !io.pbtn_release[2]; i++) cyc();
    chk("btn2_release_seen", 32'(io.pbtn_release[2]), 1);
    clr_obs();
    run(20);
    chk("btn2_repeat_after_release", 32'(obs_rpt[2]), 0);
    chk("btn2_release_single", 32'(obs_rel[2]), 0);
    // reset in the middle of the delay phase of button 3
    io.pbtn_in[3] = 1'b1;
    for (int i = 0; i < 40 && !io.pbtn_press[3]; i++) cyc();
    run(12);
    rst = 1'b0;
    #1;
    chk("rst_pbtn_db", 32'(io.pbtn_db), 0);
    chk("rst_pbtn_pulses", 32'(io.pbtn_press | io.pbtn_release | io.pbtn_repeat), 0);
    chk("rst_swtch", 32'(io.swtch_db | io.swtch_chg), 0);
    model_reset();
    run(2);
    rst = 1'b1;
    clr_obs();
    for (int i = 0; i < 40 && !io.pbtn_press[3]; i++) cyc();
    chk("btn3_repress", 32'(obs_press[3]), 1);
    chk("btn3_no_stale_repeat", 32'(obs_rpt[3]), 0);
    first = -1;
    for (int i = 1; i <= 25; i++) begin
      cyc();
      if (io.pbtn_repeat[3] && first < 0) first = i;
    end
    chk("btn3_first_repeat", 32'(first), 20);
    // random toggling with one reset in the middle
    io.pbtn_in = '0;
    io.switch_in = '0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if ($urandom_range(0, 5) == 0) begin
        int r = int'($urandom_range(0, NC - 1));
        if (r < NB) io.pbtn_in[r] = ~io.pbtn_in[r];
        else io.switch_in[r-NB] = ~io.switch_in[r-NB];
      end
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
